// File: rtl/timeunit_delay_gen.sv
// ============================================================================
// Module   : timeunit_delay_gen
// Purpose  : Multi-channel programmable delay generator. A shared prescaler
//            produces a precision tick; each channel scales it by its own
//            unit multiplier and counts a delay in units, then raises a
//            registered output and pulses done for one cycle.
// Options  : TDG_PERIODIC_EN - when defined, channels started with
//            periodic=1 toggle their output every period and stay in RUN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timeunit_delay_gen #(
  parameter int CHANNELS = 3,
  parameter int PREC_DIV = 4,
  parameter int UNIT_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          stop,
  input  logic [CHANNELS*UNIT_W-1:0]   unit,
  input  logic [CHANNELS*CNT_W-1:0]    delay,
  input  logic [CHANNELS-1:0]          periodic,
  output logic [CHANNELS-1:0]          out,
  output logic [CHANNELS-1:0]          done,
  output logic                         busy
);

  localparam int PRE_W = (PREC_DIV > 1) ? $clog2(PREC_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic                w_tick;
  logic [CHANNELS-1:0] w_run_nxt;
  logic                r_busy;

  assign w_tick = (r_pre_cnt == PRE_W'(PREC_DIV - 1));

  // Free-running prescaler shared by all channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pre_cnt <= '0;
    else if (w_tick) r_pre_cnt <= '0;
    else             r_pre_cnt <= r_pre_cnt + 1'b1;
  end

`ifndef TDG_PERIODIC_EN
  // The periodic select has no effect in one-shot-only builds
  logic w_unused_periodic;
  assign w_unused_periodic = ^periodic;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [UNIT_W-1:0] r_unit, w_unit_nxt, r_ucnt, w_ucnt_nxt, w_unit_in;
    logic [CNT_W-1:0]  r_dly, w_dly_nxt, r_dcnt, w_dcnt_nxt, w_dly_in;
    logic              r_out, w_out_nxt, r_done, w_done_nxt;
    logic              w_per_in;
`ifdef TDG_PERIODIC_EN
    logic              r_per, w_per_nxt;
`endif

    // A programmed unit of zero behaves as a unit of one tick
    assign w_unit_in = (unit[i*UNIT_W +: UNIT_W] == '0) ? UNIT_W'(1)
                                                        : unit[i*UNIT_W +: UNIT_W];
    assign w_dly_in  = delay[i*CNT_W +: CNT_W];
`ifdef TDG_PERIODIC_EN
    assign w_per_in  = periodic[i];
`else
    assign w_per_in  = 1'b0;
`endif

    // Channel state register; stop and start are evaluated before counting
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_unit  <= '0;
        r_dly   <= '0;
        r_ucnt  <= '0;
        r_dcnt  <= '0;
        r_out   <= 1'b0;
        r_done  <= 1'b0;
`ifdef TDG_PERIODIC_EN
        r_per   <= 1'b0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_unit  <= w_unit_nxt;
        r_dly   <= w_dly_nxt;
        r_ucnt  <= w_ucnt_nxt;
        r_dcnt  <= w_dcnt_nxt;
        r_out   <= w_out_nxt;
        r_done  <= w_done_nxt;
`ifdef TDG_PERIODIC_EN
        r_per   <= w_per_nxt;
`endif
      end
    end

    // Next-state: stop beats start, start beats completion
    always_comb begin
      w_state_nxt = r_state;
      w_unit_nxt  = r_unit;
      w_dly_nxt   = r_dly;
      w_ucnt_nxt  = r_ucnt;
      w_dcnt_nxt  = r_dcnt;
      w_out_nxt   = r_out;
      w_done_nxt  = 1'b0;
`ifdef TDG_PERIODIC_EN
      w_per_nxt   = r_per;
`endif
      if (stop[i]) begin
        w_state_nxt = S_IDLE;
      end else if (start[i]) begin
        w_unit_nxt  = w_unit_in;
        w_dly_nxt   = w_dly_in;
        w_ucnt_nxt  = '0;
        w_dcnt_nxt  = '0;
        w_out_nxt   = 1'b0;
        w_state_nxt = S_RUN;
`ifdef TDG_PERIODIC_EN
        w_per_nxt   = w_per_in;
`endif
        if (w_dly_in == '0) begin
          w_out_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = w_per_in ? S_RUN : S_DONE;
        end
      end else if (r_state == S_RUN && w_tick) begin
`ifdef TDG_PERIODIC_EN
        if (r_dly == '0) begin
          // Zero-delay periodic channel toggles on every precision tick
          w_out_nxt  = ~r_out;
          w_done_nxt = 1'b1;
        end else
`endif
        if (r_ucnt == r_unit - 1'b1) begin
          w_ucnt_nxt = '0;
          if (r_dcnt == r_dly - 1'b1) begin
            w_done_nxt = 1'b1;
`ifdef TDG_PERIODIC_EN
            if (r_per) begin
              w_out_nxt  = ~r_out;
              w_dcnt_nxt = '0;
            end else begin
              w_out_nxt   = 1'b1;
              w_dcnt_nxt  = r_dly;
              w_state_nxt = S_DONE;
            end
`else
            w_out_nxt   = 1'b1;
            w_dcnt_nxt  = r_dly;
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end else begin
          w_ucnt_nxt = r_ucnt + 1'b1;
        end
      end
    end

    assign w_run_nxt[i] = (w_state_nxt == S_RUN);
    assign out[i]       = r_out;
    assign done[i]      = r_done;
  end

  // Busy is registered alongside the channel states it summarises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= |w_run_nxt;
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_timeunit_delay_gen.sv
// ============================================================================
// Module   : tb_timeunit_delay_gen
// Purpose  : Scoreboard bench for timeunit_delay_gen. Expected done events
//            are queued when stimulus is issued; monitors pop and compare on
//            every done pulse. Honours TDG_PERIODIC_EN for the periodic case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timeunit_delay_gen;

  localparam int CH = 3;
  localparam int UW = 8;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   start = '0, stop = '0, periodic = '0;
  logic [CH*UW-1:0] unit = '0;
  logic [CH*CW-1:0] delay = '0;
  logic [CH-1:0]   out, done;
  logic            busy;

  logic [CH-1:0]   start4 = '0, stop4 = '0, periodic4 = '0;
  logic [CH*UW-1:0] unit4 = '0;
  logic [CH*CW-1:0] delay4 = '0;
  logic [CH-1:0]   out4, done4;
  logic            busy4;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         lo;
    int         hi;
    logic [2:0] dmask;
    logic [2:0] oexp;
    logic [2:0] ocare;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];

  timeunit_delay_gen #(.CHANNELS(CH), .PREC_DIV(1), .UNIT_W(UW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .unit(unit),
    .delay(delay), .periodic(periodic), .out(out), .done(done), .busy(busy));

  timeunit_delay_gen #(.CHANNELS(CH), .PREC_DIV(4), .UNIT_W(UW), .CNT_W(CW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .unit(unit4),
    .delay(delay4), .periodic(periodic4), .out(out4), .done(done4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic push(input int lo, input int hi, input logic [2:0] dm,
                      input logic [2:0] oe, input logic [2:0] oc);
    exp_t e;
    e.lo = lo; e.hi = hi; e.dmask = dm; e.oexp = oe; e.ocare = oc;
    q0.push_back(e);
  endtask

  // Monitor for the PREC_DIV=1 instance
  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      if (q0.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check_range("done_cycle", cyc, e.lo, e.hi);
        check("done_mask", done, e.dmask);
        check("out_at_done", out & e.ocare, e.oexp & e.ocare);
      end
    end
  end

  // Monitor for the PREC_DIV=4 instance
  always @(negedge clk) begin
    if (rst_n && done4 != '0) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", done4, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check_range("done4_cycle", cyc, e.lo, e.hi);
        check("done4_mask", done4, e.dmask);
      end
    end
  end

  // Advance to the falling edge of cycle t (at least one falling edge)
  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Called at a falling edge; returns the number of the start edge
  task automatic start_pulse(input logic [CH-1:0] m, input logic [CH-1:0] s_also, output int s);
    start = m;
    stop  = s_also;
    @(posedge clk);
    #1;
    s = cyc;
    start = '0;
    stop  = '0;
  endtask

  task automatic stop_pulse(input logic [CH-1:0] m);
    stop = m;
    @(posedge clk);
    #1;
    stop = '0;
  endtask

  task automatic set_ch(input int ch, input int u, input int d);
    unit[ch*UW +: UW]  = UW'(u);
    delay[ch*CW +: CW] = CW'(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    exp_t e;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out", out, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(cyc + 2);

    // Prescaler scaling on the PREC_DIV=4 instance: 6 ticks after start
    unit4[UW-1:0]  = 8'd2;
    delay4[CW-1:0] = 16'd3;
    e.lo = cyc + 1 + 21; e.hi = cyc + 1 + 24; e.dmask = 3'b001; e.oexp = 3'b001; e.ocare = 3'b001;
    q4.push_back(e);
    start4 = 3'b001;
    @(posedge clk); #1; s = cyc; start4 = '0;
    wait_cyc(s + 20);
    check("pre_out_early", out4[0], 0);
    wait_cyc(s + 30);
    check("pre_out_late", out4[0], 1);
    check("pre_sb_drained", q4.size(), 0);

    // Staggered one-shots, all started together
    set_ch(0, 100, 1); set_ch(1, 10, 1); set_ch(2, 100, 1);
    push(cyc + 1 + 10,  cyc + 1 + 10,  3'b010, 3'b010, 3'b111);
    push(cyc + 1 + 100, cyc + 1 + 100, 3'b101, 3'b111, 3'b111);
    start_pulse(3'b111, 3'b000, s);
    wait_cyc(s);      check("stag_busy", busy, 1);
    wait_cyc(s + 9);  check("stag_out_p9", out, 3'b000);
    wait_cyc(s + 11); check("stag_out_p11", out, 3'b010);
    wait_cyc(s + 99); check("stag_out_p99", out, 3'b010);
    wait_cyc(s + 101); check("stag_out_p101", out, 3'b111);
    check("stag_busy_end", busy, 0);

    // Zero delay with unit 5
    set_ch(0, 5, 0);
    push(cyc + 1, cyc + 1, 3'b001, 3'b001, 3'b001);
    start_pulse(3'b001, 3'b000, s);
    wait_cyc(s);     check("zero_out", out[0], 1); check("zero_busy", busy, 0);
    wait_cyc(s + 1); check("zero_done_low", done[0], 0); check("zero_busy_next", busy, 0);

    // Restart halfway through a 100-cycle delay
    set_ch(1, 1, 100);
    start_pulse(3'b010, 3'b000, s);
    wait_cyc(s + 49);
    push(cyc + 1 + 100, cyc + 1 + 100, 3'b010, 3'b010, 3'b010);
    start_pulse(3'b010, 3'b000, s2);
    wait_cyc(s + 100); check("restart_out_old", out[1], 0);
    wait_cyc(s2 + 99); check("restart_out_pre", out[1], 0);
    wait_cyc(s2 + 100); check("restart_out", out[1], 1);

    // Abort halfway through
    set_ch(2, 1, 100);
    start_pulse(3'b100, 3'b000, s);
    wait_cyc(s + 49); check("stop_busy_before", busy, 1);
    stop_pulse(3'b100);
    wait_cyc(s + 50); check("stop_busy_after", busy, 0);
    wait_cyc(s + 110); check("stop_out", out[2], 0);

    // Start and stop together: stop wins, out holds its previous 1
    set_ch(0, 1, 5);
    start_pulse(3'b001, 3'b001, s);
    wait_cyc(s);     check("ss_busy", busy, 0); check("ss_out_hold", out[0], 1);
    wait_cyc(s + 8); check("ss_out_later", out[0], 1);

    // Start on the completion edge: start wins, no done pulse there
    set_ch(1, 1, 3);
    start_pulse(3'b010, 3'b000, s);
    wait_cyc(s + 2);
    push(cyc + 1 + 3, cyc + 1 + 3, 3'b010, 3'b010, 3'b010);
    start_pulse(3'b010, 3'b000, s2);
    wait_cyc(s2);     check("cmp_start_out", out[1], 0);
    wait_cyc(s2 + 4); check("cmp_start_out_end", out[1], 1);

    // Periodic request on channel 0, unit 1, delay 4
    set_ch(0, 1, 4);
    periodic = 3'b001;
`ifdef TDG_PERIODIC_EN
    push(cyc + 1 + 4,  cyc + 1 + 4,  3'b001, 3'b001, 3'b001);
    push(cyc + 1 + 8,  cyc + 1 + 8,  3'b001, 3'b000, 3'b001);
    push(cyc + 1 + 12, cyc + 1 + 12, 3'b001, 3'b001, 3'b001);
`else
    push(cyc + 1 + 4,  cyc + 1 + 4,  3'b001, 3'b001, 3'b001);
`endif
    start_pulse(3'b001, 3'b000, s);
    periodic = '0;
    wait_cyc(s + 12);
    stop_pulse(3'b001);
    wait_cyc(s + 14);
    check("per_out_end", out[0], 1);
    check("per_busy_end", busy, 0);

    // Reset in the middle of a count
    set_ch(2, 1, 100);
    start_pulse(3'b100, 3'b000, s);
    wait_cyc(s + 30);
    rst_n = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_out4", out4, 0);
    wait_cyc(s + 32);
    rst_n = 1'b1;
    wait_cyc(s + 150);
    check("rst_out_after", out, 0);
    check("sb_drained", q0.size(), 0);
    check("sb4_drained", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timeunit_delay_gen.md
# timeunit_delay_gen

Multi-channel programmable delay generator that converts per-channel "unit × count" delays into registered output edges and completion pulses. A shared free-running prescaler provides the precision tick. Each channel scales that tick by its own unit multiplier, giving per-channel time units against one common precision. Sits beside the testbench timing infrastructure as a synthesizable stand-in for per-module `timeunit`/`timeprecision` delays, so staggered events can be scheduled from a single clock.

## Interface
- `CHANNELS`, 3, number of independent delay channels (≥1)
- `PREC_DIV`, 4, clock cycles per precision tick (≥1)
- `UNIT_W`, 8, width of the per-channel unit multiplier
- `CNT_W`, 16, width of the per-channel delay count

- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  CHANNELS  per-channel arm/restart strobe
- `stop`  in  CHANNELS  per-channel abort strobe
- `unit`  in  CHANNELS*UNIT_W  ticks per unit; channel i at `[i*UNIT_W +: UNIT_W]`
- `delay`  in  CHANNELS*CNT_W  delay in units; channel i at `[i*CNT_W +: CNT_W]`
- `periodic`  in  CHANNELS  periodic-mode select; used only with `TDG_PERIODIC_EN`
- `out`  out  CHANNELS  registered delayed output per channel
- `done`  out  CHANNELS  one-cycle completion pulse per channel
- `busy`  out  1  OR of all channels in RUN

## Operation
- Prescaler: `pre_cnt` counts 0..PREC_DIV-1 and wraps. `tick` = (`pre_cnt`==PREC_DIV-1). Free-running from reset; never restarted by channel activity.
- Per-channel FSM states: IDLE, RUN, DONE.
  - Reset: all channels in IDLE.
- On `start[i]` in any state:
  - Latch `unit` and `delay` into channel registers.
  - Clear `unit_cnt` and `dly_cnt`.
  - `out[i]` ← 0; state → RUN.
  - A latched `unit` of 0 is treated as 1.
- Latched `delay`==0: `out[i]` ← 1 and `done[i]` ← 1 at the start edge; state → DONE (or stays in RUN in periodic mode).
- In RUN, on each edge where `tick`=1, excluding the start edge:
  - `unit_cnt`++.
  - When `unit_cnt` reaches unit-1: `unit_cnt` ← 0 and `dly_cnt`++.
  - When `dly_cnt` reaches `delay`: `out[i]` ← 1, `done[i]` ← 1 for one cycle, state → DONE.
- Counter widths are exact. No wrap is possible: counters stop at the latched limit.
- `stop[i]`: state → IDLE, `out[i]` holds its current value, no `done` pulse.
- DONE: `out[i]` held at 1 until the next `start[i]`.
- Channels are fully independent; only the prescaler is shared.

## Timing
- Reset values: `out`=0, `done`=0, `busy`=0, `pre_cnt`=0, all channel counters 0.
- Latency: `out[i]` rises at the edge sampling the (delay×unit)-th tick after the start edge.
  - With PREC_DIV=1 this is exactly delay×unit cycles after the start edge.
  - Otherwise the rise falls between (delay×unit−1)×PREC_DIV+1 and delay×unit×PREC_DIV cycles.
- `done[i]` is asserted in the same cycle `out[i]` rises (or toggles) and is low in all other cycles.
- `busy` is registered with the FSMs; it is high in any cycle where at least one channel is in RUN.
- Simultaneous events:
  - `start` and `stop` together: `stop` wins.
  - `start` on the completion edge: `start` wins; `out` goes to 0, no `done` pulse.
- Reset asserted mid-count: immediate return to reset values. No completion is reported after `rst_n` deasserts.

## Configuration
- `TDG_PERIODIC_EN` defined:
  - `periodic[i]` is latched at start.
  - In periodic mode, completion toggles `out[i]` instead of setting it to 1.
  - `dly_cnt` and `unit_cnt` clear, the channel stays in RUN, and `done[i]` pulses every period.
  - A latched `delay`==0 in periodic mode toggles `out[i]` every tick.
- `TDG_PERIODIC_EN` not defined:
  - The `periodic` port is present but ignored; all channels are one-shot.
  - No toggle logic is synthesized.

## Test plan
- Staggered one-shots: CHANNELS=3, PREC_DIV=1; unit = 100, 10, 100; delay = 1, 1, 1; all channels started on the same edge. Required: `out`=000 at +9; 010 at +11; 010 at +99; 111 at +101. `done` pulses on ch1 at +10 and on ch0/ch2 at +100.
- Zero delay: delay=0, unit=5. Required: `out`=1 and `done`=1 at the start edge; `done`=0 on the next cycle; `busy` never rises.
- Prescaler scaling: PREC_DIV=4, unit=2, delay=3. Required: `out` rises between 21 and 24 cycles after start, with exactly one `done` pulse.
- Restart/abort:
  - Re-`start` at cycle 50 of a 100-cycle delay: `out` rises 100 cycles after the second start.
  - `stop` at cycle 50: `out` stays 0 and `busy` falls on the next edge.
  - `start` and `stop` in the same cycle: channel goes to IDLE.
- Reset mid-count: assert `rst_n`=0 at cycle 30 of 100. Required: all outputs 0 immediately; no `done` ever appears after release.
- Periodic (with `TDG_PERIODIC_EN`): PREC_DIV=1, unit=1, delay=4, periodic=1. Required: `out` toggles at +4, +8, +12 with a `done` pulse each time. The same stimulus without the macro gives a single rise at +4.
